// File: rtl/fpu_rsp_pkg.sv
// fpu_rsp_pkg: response type, IEEE exception flag bit positions and rounding-mode codes
package fpu_rsp_pkg;
  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  flags;
  } fpu_rsp_t;
  localparam int FLAG_INVALID   = 4;
  localparam int FLAG_DIVZERO   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;
  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RDN = 2'b10,
    RM_RUP = 2'b11
  } fpu_rm_e;
endpackage

// File: rtl/fpu_rsp_fifo.sv
// fpu_rsp_fifo: first-word-fall-through response FIFO, head entry always visible on rd_data
module fpu_rsp_fifo
  import fpu_rsp_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fpu_rsp_t,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  T            wr_data,
  input  logic        rd_en,
  output T            rd_data,
  output logic        empty,
  output logic [AW:0] count
);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  T              mem_q [DEPTH];
  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end
  assign rd_data = mem_q[rd_ptr_q];
  assign empty   = cnt_q == '0;
  assign count   = cnt_q;
endmodule

// File: rtl/fpu_rsp_buffer.sv
// fpu_rsp_buffer: issues requests to a fixed-latency FPU core and buffers results in order.
// Optional sticky exception-flag accumulator enabled by defining FPU_STICKY_FLAGS_EN.
module fpu_rsp_buffer
  import fpu_rsp_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_fpa,
  input  logic [63:0] req_fpb,
  input  logic        req_db,
  input  logic        req_sub,
  input  logic        req_fdiv,
  input  logic [1:0]  req_rm,
  output logic [63:0] fpa,
  output logic [63:0] fpb,
  output logic        db,
  output logic        normal,
  output logic        sub,
  output logic        fdiv,
  output logic [1:0]  RM,
  input  logic [63:0] fp_add_out,
  input  logic [4:0]  IEEp_add,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic [4:0]  rsp_flags,
  input  logic        flags_clr,
  output logic [4:0]  sticky_flags
);
  localparam int AW = $clog2(DEPTH);
  logic [63:0]    fpa_q, fpa_d, fpb_q, fpb_d;
  logic           db_q, db_d, normal_q, normal_d, sub_q, sub_d, fdiv_q, fdiv_d;
  logic [1:0]     rm_q, rm_d;
  logic [LAT-1:0] vld_q, vld_d, dbp_q, dbp_d;
  logic [4:0]     used;
  logic           accept, capture, pop, empty;
  logic [AW:0]    count;
  fpu_rsp_t       cap_rsp, head;
  always_comb begin
    used      = 5'(count) + 5'($countones(vld_q));
    req_ready = !rst && used < 5'(DEPTH);
    accept    = req_valid && req_ready;
    capture   = vld_q[LAT-1];
    rsp_valid = !rst && !empty;
    pop       = rsp_valid && rsp_ready;
    fpa_d     = accept ? req_fpa : fpa_q;
    fpb_d     = accept ? req_fpb : fpb_q;
    db_d      = accept ? req_db : db_q;
    sub_d     = accept ? req_sub : sub_q;
    fdiv_d    = accept ? req_fdiv : fdiv_q;
    rm_d      = accept ? req_rm : rm_q;
    normal_d  = accept | normal_q;
    // the precision bit travels alongside the valid bit so each capture knows its own width
    vld_d     = LAT'({vld_q, accept});
    dbp_d     = LAT'({dbp_q, req_db});
    cap_rsp   = '{data: dbp_q[LAT-1] ? fp_add_out : {32'h0, fp_add_out[31:0]}, flags: IEEp_add};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fpa_q    <= '0;
      fpb_q    <= '0;
      db_q     <= 1'b0;
      sub_q    <= 1'b0;
      fdiv_q   <= 1'b0;
      rm_q     <= 2'b00;
      normal_q <= 1'b0;
      vld_q    <= '0;
      dbp_q    <= '0;
    end else begin
      fpa_q    <= fpa_d;
      fpb_q    <= fpb_d;
      db_q     <= db_d;
      sub_q    <= sub_d;
      fdiv_q   <= fdiv_d;
      rm_q     <= rm_d;
      normal_q <= normal_d;
      vld_q    <= vld_d;
      dbp_q    <= dbp_d;
    end
  end
  fpu_rsp_fifo #(.DEPTH(DEPTH), .T(fpu_rsp_t)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(capture),
    .wr_data(cap_rsp),
    .rd_en(pop),
    .rd_data(head),
    .empty(empty),
    .count(count)
  );
  assign fpa       = fpa_q;
  assign fpb       = fpb_q;
  assign db        = db_q;
  assign normal    = normal_q;
  assign sub       = sub_q;
  assign fdiv      = fdiv_q;
  assign RM        = rm_q;
  assign rsp_data  = head.data;
  assign rsp_flags = head.flags;
`ifdef FPU_STICKY_FLAGS_EN
  logic [4:0] sticky_q, sticky_d;
  always_comb sticky_d = (flags_clr ? 5'b0 : sticky_q) | (pop ? head.flags : 5'b0);
  always_ff @(posedge clk) begin
    if (rst) sticky_q <= '0;
    else sticky_q <= sticky_d;
  end
  assign sticky_flags = sticky_q;
`else
  logic unused_clr;
  assign unused_clr   = flags_clr;
  assign sticky_flags = 5'b0;
`endif
endmodule

// File: tb/tb_fpu_rsp_buffer.sv
// tb_fpu_rsp_buffer: directed scoreboard bench for fpu_rsp_buffer with a stub FPU core
module tb_fpu_rsp_buffer;
  localparam int LAT = 2;
  localparam int DEPTH = 4;
`ifdef FPU_STICKY_FLAGS_EN
  localparam logic [4:0] STICKY_EXP = 5'b10001;
`else
  localparam logic [4:0] STICKY_EXP = 5'b00000;
`endif
  logic clk = 0, rst = 1, req_valid = 0, req_db = 0, req_sub = 0, req_fdiv = 0;
  logic rsp_ready = 0, flags_clr = 0;
  logic [63:0] req_fpa = 0, req_fpb = 0;
  logic [1:0] req_rm = 0;
  logic req_ready, db, normal, sub, fdiv, rsp_valid;
  logic [63:0] fpa, fpb, rsp_data, fp_add_out;
  logic [1:0] RM;
  logic [4:0] rsp_flags, sticky_flags, IEEp_add;
  logic [68:0] stub_q = '0;
  logic [68:0] exp_q[$];
  logic [68:0] last = '0;
  logic held = 0;
  int checks = 0, errors = 0, cyc = 0, acc_cnt = 0, rsp_cnt = 0, acc_cyc = 0;
  logic [31:0] sa[6] = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3FC00000, 32'h40800000};
  logic [31:0] sb[6] = '{32'h40000000, 32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3FC00000, 32'h40800000};
  logic [31:0] ss[6] = '{32'h40400000, 32'h40000000, 32'h40800000, 32'h3F800000, 32'h40400000, 32'h41000000};

  fpu_rsp_buffer #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_fpa(req_fpa), .req_fpb(req_fpb), .req_db(req_db), .req_sub(req_sub),
    .req_fdiv(req_fdiv), .req_rm(req_rm), .fpa(fpa), .fpb(fpb), .db(db),
    .normal(normal), .sub(sub), .fdiv(fdiv), .RM(RM), .fp_add_out(fp_add_out),
    .IEEp_add(IEEp_add), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .flags_clr(flags_clr),
    .sticky_flags(sticky_flags)
  );

  always #5 clk = ~clk;

  // stub core: real add of the drive-port operands; upper word of a single result carries junk
  function automatic logic [68:0] stub_fn(input logic [63:0] a, input logic [63:0] b, input logic d);
    logic [63:0] da, dbb, r;
    if (d) r = $realtobits($bitstoreal(a) + $bitstoreal(b));
    else begin
      da  = {a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'b0};
      dbb = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'b0};
      r   = $realtobits($bitstoreal(da) + $bitstoreal(dbb));
      r   = {a[63:32], r[63], 8'(r[62:52] - 11'd896), r[51:29]};
    end
    return {r, a[63:59]};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
    stub_q <= stub_fn(fpa, fpb, db);
  end
  assign fp_add_out = stub_q[68:5];
  assign IEEp_add   = stub_q[4:0];

  task automatic chk(input string n, input logic [68:0] act, input logic [68:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) held = 0;
    else begin
      if (held && rsp_valid) chk("hold_stable", {rsp_data, rsp_flags}, last);
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got %h expected no response", {rsp_data, rsp_flags});
        end else chk("rsp_order", {rsp_data, rsp_flags}, exp_q.pop_front());
      end
      held = rsp_valid && !rsp_ready;
      last = {rsp_data, rsp_flags};
    end
  end

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic d,
                       input logic [63:0] ed, input logic [4:0] ef);
    int n = 0;
    req_valid = 1;
    req_fpa = a;
    req_fpb = b;
    req_db = d;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL accept_timeout: req_ready=%0b expected 1", req_ready);
    end else begin
      exp_q.push_back({ed, ef});
      acc_cyc = cyc;
    end
    @(posedge clk);
    #1 req_valid = 0;
  endtask

  task automatic issue_s(input int i, input logic [4:0] k);
    issue({k, 27'h0, sa[i]}, {32'hDEADBEEF, sb[i]}, 1'b0, {32'h0, ss[i]}, k);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 69'(exp_q.size()), 69'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n, v, a0, r0, f;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 69'(rsp_valid), 69'(0));
    chk("rst_req_ready", 69'(req_ready), 69'(0));
    chk("rst_fpa", 69'(fpa), 69'(0));
    chk("rst_normal", 69'(normal), 69'(0));
    chk("rst_rm", 69'(RM), 69'(0));
    chk("rst_sticky", 69'(sticky_flags), 69'(0));
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("ready_after_rst", 69'(req_ready), 69'(1));
    @(posedge clk);
    #1;
    // single 1.0 + 2.0 with drive-port and latency checks
    rsp_ready = 1;
    req_rm = 2'b01;
    req_sub = 1;
    issue(64'h0000_0000_3F80_0000, 64'h0000_0000_4000_0000, 1'b0, 64'h0000_0000_4040_0000, 5'h00);
    chk("drv_fpa", 69'(fpa), 69'(64'h3F80_0000));
    chk("drv_fpb", 69'(fpb), 69'(64'h4000_0000));
    chk("drv_db", 69'(db), 69'(0));
    chk("drv_normal", 69'(normal), 69'(1));
    chk("drv_sub", 69'(sub), 69'(1));
    chk("drv_rm", 69'(RM), 69'(2'b01));
    req_sub = 0;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 69'(cyc - acc_cyc), 69'(LAT + 1));
    wait_drain();
    issue(64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b1, 64'h4008_0000_0000_0000, 5'b00111);
    issue(64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b1, 64'h4010_0000_0000_0000, 5'b01000);
    wait_drain();
    // backpressure: four fill the buffer, the fifth must wait for credit
    rsp_ready = 0;
    r0 = rsp_cnt;
    for (int i = 0; i < 4; i++) issue_s(i, 5'(i + 1));
    @(negedge clk);
    chk("full_ready", 69'(req_ready), 69'(0));
    a0 = acc_cnt;
    fork
      issue_s(4, 5'd5);
      begin
        repeat (6) @(negedge clk);
        chk("held_5th", 69'(acc_cnt - a0), 69'(0));
        chk("held_no_pop", 69'(rsp_cnt - r0), 69'(0));
        @(posedge clk);
        #1 rsp_ready = 1;
      end
    join
    wait_drain();
    chk("bp_rsp_cnt", 69'(rsp_cnt - r0), 69'(5));
    // continuous stream of 20 wraps the pointers several times
    r0 = rsp_cnt;
    issue_s(0, 5'd1);
    f = acc_cyc;
    for (int i = 1; i < 20; i++) issue_s(i % 6, 5'(i + 1));
    chk("stream_rate", 69'(acc_cyc - f), 69'(19));
    wait_drain();
    chk("stream_rsp_cnt", 69'(rsp_cnt - r0), 69'(20));
    // reset with one queued and two in flight
    rsp_ready = 0;
    issue_s(0, 5'd3);
    repeat (LAT) @(posedge clk);
    #1;
    issue_s(1, 5'd4);
    issue_s(2, 5'd5);
    rst = 1;
    exp_q.delete();
    @(negedge clk);
    chk("rst_flush_valid", 69'(rsp_valid), 69'(0));
    @(posedge clk);
    #1 rst = 0;
    v = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) v++;
    end
    chk("no_rsp_after_rst", 69'(v), 69'(0));
    // sticky accumulation and clear
    @(posedge clk);
    #1 rsp_ready = 1;
    flags_clr = 1;
    @(posedge clk);
    #1 flags_clr = 0;
    issue_s(0, 5'b00001);
    issue_s(1, 5'b10000);
    wait_drain();
    chk("sticky_acc", 69'(sticky_flags), 69'(STICKY_EXP));
    flags_clr = 1;
    @(posedge clk);
    #1 flags_clr = 0;
    chk("sticky_clr", 69'(sticky_flags), 69'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
